// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: run/pause state encoding and BCD digit limits.
// Also used by the display driver and the clock divider.
package stopwatch_pkg;

   localparam int BCD_W        = 4;
   localparam int DIG_MAX_ONES = 9;
   localparam int SEC_TENS_MAX = 5;

   typedef enum logic {
      ST_PAUSED = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   function automatic logic [BCD_W-1:0] bcd_tens(input int v);
      return BCD_W'(v / 10);
   endfunction

   function automatic logic [BCD_W-1:0] bcd_ones(input int v);
      return BCD_W'(v % 10);
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX to 00; carry_out flags the wrapping increment.
// Digits update on the clk edge that samples inc (1-cycle latency); no backpressure.
module bcd_mod_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic             carry_out,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   localparam logic [BCD_W-1:0] MAX_T = bcd_tens(MAX);
   localparam logic [BCD_W-1:0] MAX_O = bcd_ones(MAX);

   logic [BCD_W-1:0] r_tens;
   logic [BCD_W-1:0] r_ones;
   logic             w_at_max;

   assign w_at_max  = (r_tens == MAX_T) && (r_ones == MAX_O);
   assign carry_out = inc && w_at_max;
   assign tens      = r_tens;
   assign ones      = r_ones;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tens <= '0;
         r_ones <= '0;
      end else if (inc) begin
         if (w_at_max) begin
            r_tens <= '0;
            r_ones <= '0;
         end else if (r_ones == BCD_W'(DIG_MAX_ONES)) begin
            r_ones <= '0;
            r_tens <= r_tens + BCD_W'(1);
         end else begin
            r_ones <= r_ones + BCD_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core with run/pause and per-field adjust; STOPWATCH_SAT_EN makes counting saturate with done.
// All outputs registered, 1-cycle latency from the sampled tick; no backpressure.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN = 59,
   parameter int MAX_SEC = 59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_1hz,
   input  logic             tick_2hz,
   input  logic             pause_pulse,
   input  logic             adj,
   input  logic             sel,
   output logic [BCD_W-1:0] minutes_1,
   output logic [BCD_W-1:0] minutes_0,
   output logic [BCD_W-1:0] seconds_1,
   output logic [BCD_W-1:0] seconds_0,
   output logic             running,
   output logic             done
);

   state_t r_state;
   state_t w_state_nxt;

   logic w_run_tick;
   logic w_sec_count;
   logic w_sec_inc;
   logic w_min_inc;
   logic w_sec_carry;
   logic w_unused_min_carry;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   // pause_pulse toggles even in adjust mode; it only matters once adj drops
   always_comb begin
      w_state_nxt = r_state;
      if (pause_pulse) begin
         w_state_nxt = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
      end
   end

   assign running = (r_state == ST_RUN);

`ifdef STOPWATCH_SAT_EN
   logic r_done;
   logic w_at_max;

   assign w_at_max = (minutes_1 == bcd_tens(MAX_MIN)) && (minutes_0 == bcd_ones(MAX_MIN)) &&
                     (seconds_1 == BCD_W'(SEC_TENS_MAX)) && (seconds_0 == BCD_W'(DIG_MAX_ONES));
   assign w_run_tick  = !adj && tick_1hz && (r_state == ST_RUN) && !r_done;
   assign w_sec_count = w_run_tick && !w_at_max;

   always_ff @(posedge clk) begin
      if (rst)                          r_done <= 1'b0;
      else if (adj && tick_2hz)         r_done <= 1'b0;
      else if (w_run_tick && w_at_max)  r_done <= 1'b1;
   end

   assign done = r_done;
`else
   assign w_run_tick  = !adj && tick_1hz && (r_state == ST_RUN);
   assign w_sec_count = w_run_tick;
   assign done        = 1'b0;
`endif

   // adjust mode steers tick_2hz to one field and breaks the seconds->minutes carry
   assign w_sec_inc = adj ? (tick_2hz && sel)  : w_sec_count;
   assign w_min_inc = adj ? (tick_2hz && !sel) : w_sec_carry;

   bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_sec_inc),
      .carry_out (w_sec_carry),
      .tens      (seconds_1),
      .ones      (seconds_0)
   );

   bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_min_inc),
      .carry_out (w_unused_min_carry),
      .tens      (minutes_1),
      .ones      (minutes_0)
   );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed-vector bench for stopwatch_counter; expected MM:SS/running/done snapshots are queued
// by the stimulus and compared by an independent monitor on the falling edge.
module tb_stopwatch_counter;

`ifdef STOPWATCH_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, tick_1hz, tick_2hz, pause_pulse, adj, sel;
   logic [3:0] minutes_1, minutes_0, seconds_1, seconds_0;
   logic       running, done;

   always #5 clk = ~clk;

   stopwatch_counter #(.MAX_MIN(59), .MAX_SEC(59)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_1hz    (tick_1hz),
      .tick_2hz    (tick_2hz),
      .pause_pulse (pause_pulse),
      .adj         (adj),
      .sel         (sel),
      .minutes_1   (minutes_1),
      .minutes_0   (minutes_0),
      .seconds_1   (seconds_1),
      .seconds_0   (seconds_0),
      .running     (running),
      .done        (done)
   );

   logic [17:0] exp_q[$];
   string       name_q[$];
   logic        chk_req = 1'b0;
   int          total = 0;
   int          bad = 0;
   logic [17:0] mon_exp;
   logic [17:0] mon_act;
   string       mon_nm;

   function automatic logic [17:0] snap(input int mm, input int ss, input logic run, input logic dn);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, dn};
   endfunction

   // Monitor: pops one expectation per check strobe and compares against the live outputs.
   always @(negedge clk) begin
      if (chk_req) begin
         total = total + 1;
         mon_act = {minutes_1, minutes_0, seconds_1, seconds_0, running, done};
         if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL no_expectation: got %h%h:%h%h run=%b done=%b", mon_act[17:14],
                     mon_act[13:10], mon_act[9:6], mon_act[5:2], mon_act[1], mon_act[0]);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            if (mon_act !== mon_exp) begin
               bad = bad + 1;
               $display("FAIL %s: got %h%h:%h%h run=%b done=%b, want %h%h:%h%h run=%b done=%b",
                        mon_nm, mon_act[17:14], mon_act[13:10], mon_act[9:6], mon_act[5:2],
                        mon_act[1], mon_act[0], mon_exp[17:14], mon_exp[13:10], mon_exp[9:6],
                        mon_exp[5:2], mon_exp[1], mon_exp[0]);
            end
         end
      end
   end

   task automatic cyc(input logic t1, input logic t2, input logic pp, input logic r);
      tick_1hz    = t1;
      tick_2hz    = t2;
      pause_pulse = pp;
      rst         = r;
      @(posedge clk);
      #1;
      tick_1hz    = 1'b0;
      tick_2hz    = 1'b0;
      pause_pulse = 1'b0;
      rst         = 1'b0;
   endtask

   task automatic n1(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic n2(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic expect_st(input string nm, input int mm, input int ss, input logic run, input logic dn);
      exp_q.push_back(snap(mm, ss, run, dn));
      name_q.push_back(nm);
      chk_req = 1'b1;
      @(negedge clk);
      #1;
      chk_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0; pause_pulse = 1'b0; adj = 1'b0; sel = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      expect_st("reset_with_tick", 0, 0, 1'b1, 1'b0);

      // Wrap of seconds into minutes
      n1(9);  expect_st("run_00_09", 0, 9, 1'b1, 1'b0);
      n1(1);  expect_st("run_ones_roll", 0, 10, 1'b1, 1'b0);
      n1(49); expect_st("run_00_59", 0, 59, 1'b1, 1'b0);
      n1(1);  expect_st("run_01_00", 1, 0, 1'b1, 1'b0);

      // Preload 59:59 through adjust mode, then one more tick at the top
      adj = 1'b1; sel = 1'b0;
      n2(58); expect_st("adj_min_59", 59, 0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); expect_st("adj_ignores_1hz", 59, 0, 1'b1, 1'b0);
      sel = 1'b1;
      n2(59); expect_st("adj_sec_59", 59, 59, 1'b1, 1'b0);
      adj = 1'b0;
      n1(1);  expect_st("top_tick", SAT ? 59 : 0, SAT ? 59 : 0, 1'b1, SAT);
      n1(1);  expect_st("top_tick2", SAT ? 59 : 0, SAT ? 59 : 1, 1'b1, SAT);
      adj = 1'b1; sel = 1'b1;
      n2(1);  expect_st("adj_after_top", SAT ? 59 : 0, SAT ? 0 : 2, 1'b1, 1'b0);
      adj = 1'b0;
      n1(1);  expect_st("run_after_top", SAT ? 59 : 0, SAT ? 1 : 3, 1'b1, 1'b0);

      // Pause / resume
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n1(5);  expect_st("pause_pre", 0, 5, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0); expect_st("paused", 0, 5, 1'b0, 1'b0);
      n1(10); expect_st("paused_ticks", 0, 5, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0); expect_st("resumed", 0, 5, 1'b1, 1'b0);
      n1(1);  expect_st("resumed_tick", 0, 6, 1'b1, 1'b0);

      // pause_pulse and tick together use the pre-toggle state
      n1(4);  expect_st("pre_simul", 0, 10, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0); expect_st("simul_pause_tick", 0, 11, 1'b0, 1'b0);
      n1(1);  expect_st("simul_then_paused", 0, 11, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n1(1);  expect_st("simul_resume", 0, 12, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0); expect_st("normal_ignores_2hz", 0, 12, 1'b1, 1'b0);

      // Adjust minutes: 61 pulses from 00:00 with stray 1 Hz ticks mixed in
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      adj = 1'b1; sel = 1'b0;
      for (int i = 0; i < 59; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         if (i % 10 == 0) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      end
      expect_st("adj_min_59b", 59, 0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0); expect_st("adj_min_wrap", 0, 0, 1'b1, 1'b0);
      n2(1);  expect_st("adj_min_61", 1, 0, 1'b1, 1'b0);

      // Adjust seconds wraps without carrying into minutes
      n2(2);  expect_st("adj_min_03", 3, 0, 1'b1, 1'b0);
      sel = 1'b1;
      n2(58); expect_st("adj_sec_58", 3, 58, 1'b1, 1'b0);
      n2(3);  expect_st("adj_sec_wrap", 3, 1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0); expect_st("adj_pause_toggle", 3, 1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); expect_st("adj_paused_1hz", 3, 1, 1'b0, 1'b0);
      adj = 1'b0;
      n1(1);  expect_st("exit_adj_paused", 3, 1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n1(1);  expect_st("exit_adj_resumed", 3, 2, 1'b1, 1'b0);

      // Reset mid-operation while adjusting and paused
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      adj = 1'b1; sel = 1'b0;
      n2(12);
      sel = 1'b1;
      n2(34);
      cyc(1'b0, 1'b0, 1'b1, 1'b0); expect_st("preload_12_34", 12, 34, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1); expect_st("reset_in_adj", 0, 0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); expect_st("post_reset_adj", 0, 0, 1'b1, 1'b0);
      adj = 1'b0;
      n1(1);  expect_st("post_reset_run", 0, 1, 1'b1, 1'b0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Time-keeping core of the stopwatch. It produces the four BCD digits (MM:SS) and carries the adjust/select mode that the 7-segment display driver consumes.
- Counts seconds while running, supports pause/resume, and supports manual adjustment of the minutes or seconds field.
- Sits between the clock-divider enables and the button-conditioning logic on the input side, and the display driver on the output side.

Parameters:
- MAX_MIN, 59, highest minutes value before wrap/saturate (legal range 1..99)
- MAX_SEC, 59, highest seconds value before wrap/saturate (fixed-use; do not override)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-clk-wide enable pulse at 1 Hz, clk domain
- tick_2hz  in  1  one-clk-wide enable pulse at 2 Hz, clk domain
- pause_pulse  in  1  debounced one-clk pulse; toggles RUN/PAUSED
- adj  in  1  1 = adjust mode
- sel  in  1  adjust target: 0 = minutes, 1 = seconds
- minutes_1  out  4  minutes tens, BCD
- minutes_0  out  4  minutes ones, BCD
- seconds_1  out  4  seconds tens, BCD
- seconds_0  out  4  seconds ones, BCD
- running  out  1  1 when state = RUN
- done  out  1  saturation flag; see Optional Feature

Behaviour:
- Reset (rst = 1 at a clk edge):
  - all digit outputs = 0
  - state = RUN, so running = 1
  - done = 0
  - reset overrides every other input in the same cycle
- All outputs are registered. Updates appear on the clk edge that samples the enabling tick, i.e. 1-cycle latency.
- State machine (2 states, RUN and PAUSED):
  - pause_pulse toggles the state.
  - A tick sampled in the same cycle as pause_pulse is processed using the pre-toggle state.
- Normal mode (adj = 0):
  - In RUN, each tick_1hz increments seconds. seconds 59 -> 00 and carries +1 into minutes.
  - minutes MAX_MIN with a carry -> 00, i.e. 59:59 -> 00:00.
  - In PAUSED, ticks are ignored. tick_2hz is ignored in normal mode.
- Adjust mode (adj = 1):
  - Normal counting is suspended regardless of state. tick_1hz is ignored.
  - Each tick_2hz increments only the selected field, which wraps independently with no carry: seconds 59 -> 00, minutes MAX_MIN -> 00.
  - The unselected field holds.
  - pause_pulse still toggles the state; the new state takes effect when adj returns to 0.
- Mode changes of adj or sel take effect in the same cycle they are sampled. Tick selection is combinational on the current adj.
- BCD arithmetic:
  - A ones digit of 9 rolls to 0 and increments tens.
  - Tens wraps at 5 for seconds and at MAX_MIN/10 for minutes.
  - Non-BCD digit values are unreachable from reset.
- running is registered state. It is 1 in RUN even while adj = 1.

Optional Feature:
- Macro: STOPWATCH_SAT_EN
- Defined:
  - In normal mode, a tick_1hz at MAX_MIN:59 holds the count and sets done = 1.
  - done clears on rst, or on any adjust-mode increment.
  - While done = 1, normal ticks are ignored.
  - Adjust-mode wrapping is unchanged.
- Undefined: counting wraps to 00:00 as described in Behaviour, and done is tied to 0.

Decomposition:
- Shared package (stopwatch_pkg):
  - state encoding constants ST_RUN and ST_PAUSED
  - BCD_W = 4
  - DIG_MAX_ONES = 9
  - SEC_TENS_MAX = 5
  - these constants are reused by the display driver and the clock divider
- Sub-module: bcd_mod_counter.
  - Two-digit BCD counter with parameter MAX and ports inc, carry_out, tens, ones.
  - Synchronous active-high reset.
  - Instantiated twice: seconds with MAX = 59, minutes with MAX = MAX_MIN.
  - The top level handles the state machine, mode muxing of inc sources, and saturation.

Test Plan:
- Wrap: rst, then run 60 tick_1hz pulses -> reads 01:00. Preload via adjust to 59:59, then 1 tick_1hz -> 00:00 (macro undefined), or holds 59:59 with done = 1 (macro defined).
- Pause: at 00:05 assert pause_pulse, then 10 tick_1hz -> remains 00:05 with running = 0. Assert pause_pulse again, then 1 tick -> 00:06.
- Adjust minutes: adj = 1, sel = 0, 61 tick_2hz pulses from 00:00 -> 01:00 (minutes wrapped once), seconds unchanged. tick_1hz pulses during this have no effect.
- Adjust seconds: adj = 1, sel = 1 at 03:58, 3 tick_2hz pulses -> 03:01 with no carry into minutes.
- Simultaneous events: pause_pulse and tick_1hz in the same cycle while in RUN at 00:10 -> 00:11 and running = 0 next cycle. rst together with tick_1hz -> 00:00.
- Reset mid-operation: rst asserted at 12:34 while adj = 1 -> all digits 0 and running = 1 on the next edge. Counting resumes on the first tick_1hz once adj = 0.
